// File: rtl/load_store_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_queue_pkg
// Description : Shared widths, LSQ entry and memory_fu issue packet types.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_queue_pkg;

   localparam int PR_WIDTH          = 6;
   localparam int ROB_WIDTH         = 4;
   localparam int LSQ_DEPTH_DEFAULT = 8;

   typedef struct packed {
      logic                 ls_valid;
      logic                 operation;
      logic [2:0]           funct3;
      logic [31:0]          offset;
      logic [ROB_WIDTH-1:0] Wrob;
      logic [4:0]           archDest;
      logic [PR_WIDTH-1:0]  pDest;
   } loadStoreReservationEntry_t;

   typedef struct packed {
      logic                 valid;
      logic                 operation;
      logic [2:0]           funct3;
      logic [31:0]          offset;
      logic [PR_WIDTH-1:0]  ps1;
      logic                 ps1_ready;
      logic [PR_WIDTH-1:0]  ps2;
      logic                 ps2_ready;
      logic [ROB_WIDTH-1:0] wrob;
      logic [4:0]           arch_dest;
      logic [PR_WIDTH-1:0]  pdest;
   } lsq_entry_t;

   // p0 is hard-wired zero, so it never waits on a producer.
   function automatic logic operand_ready(input logic                rdy,
                                          input logic [PR_WIDTH-1:0] ps,
                                          input logic                cdb_v,
                                          input logic [PR_WIDTH-1:0] cdb_reg);
      return rdy | (ps == '0) | (cdb_v & (cdb_reg == ps));
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : load_store_queue
// Description : In-order LSQ; CDB wakeup, head-only issue to memory_fu.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_queue
   import load_store_queue_pkg::*;
#(
   parameter int LSQ_DEPTH = LSQ_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       branch,
   input  logic                       disp_valid,
   input  logic                       disp_operation,
   input  logic [2:0]                 disp_funct3,
   input  logic [31:0]                disp_offset,
   input  logic [PR_WIDTH-1:0]        disp_ps1,
   input  logic                       disp_ps1_ready,
   input  logic [PR_WIDTH-1:0]        disp_ps2,
   input  logic                       disp_ps2_ready,
   input  logic [ROB_WIDTH-1:0]       disp_wrob,
   input  logic [4:0]                 disp_arch_dest,
   input  logic [PR_WIDTH-1:0]        disp_pdest,
   input  logic [ROB_WIDTH-1:0]       rob_head,
   input  logic                       cdb_valid,
   input  logic [PR_WIDTH-1:0]        cdb_phys_reg,
   input  logic                       mem_fu_ready,
   output logic                       lsq_full,
   output logic                       lsq_empty,
   output loadStoreReservationEntry_t ls_pkg,
   output logic [PR_WIDTH-1:0]        issue_ps1,
   output logic [PR_WIDTH-1:0]        issue_ps2
);

   localparam int                 LSQ_PTR_W = $clog2(LSQ_DEPTH);
   localparam logic [LSQ_PTR_W:0] C_FULL    = (LSQ_PTR_W+1)'(LSQ_DEPTH);
   localparam logic [LSQ_PTR_W:0] C_ONE     = (LSQ_PTR_W+1)'(1);
   localparam logic [LSQ_PTR_W-1:0] C_PTR_ONE = LSQ_PTR_W'(1);

   lsq_entry_t                 r_entries [LSQ_DEPTH];
   logic [LSQ_PTR_W-1:0]       r_head;
   logic [LSQ_PTR_W-1:0]       r_tail;
   logic [LSQ_PTR_W:0]         r_count;
   loadStoreReservationEntry_t r_ls_pkg;
   logic [PR_WIDTH-1:0]        r_issue_ps1;
   logic [PR_WIDTH-1:0]        r_issue_ps2;

   logic [LSQ_DEPTH-1:0]       w_wake1;
   logic [LSQ_DEPTH-1:0]       w_wake2;
   lsq_entry_t                 w_head;
   lsq_entry_t                 w_new;
   logic                       w_eligible;
   logic                       w_issue;
   logic                       w_disp;

   generate
      for (genvar i = 0; i < LSQ_DEPTH; i++) begin : g_wake
         assign w_wake1[i] = r_entries[i].valid & cdb_valid & (cdb_phys_reg == r_entries[i].ps1);
         assign w_wake2[i] = r_entries[i].valid & cdb_valid & (cdb_phys_reg == r_entries[i].ps2);
      end
   endgenerate

   assign lsq_full   = (r_count == C_FULL);
   assign lsq_empty  = (r_count == '0);
   assign w_head     = r_entries[r_head];
   assign w_eligible = w_head.valid & w_head.ps1_ready & w_head.ps2_ready &
                       (~w_head.operation | (w_head.wrob == rob_head));
   // Holding off while ls_valid is high keeps memory_fu from seeing a double pulse.
   assign w_issue    = w_eligible & mem_fu_ready & ~r_ls_pkg.ls_valid & ~branch;
   assign w_disp     = disp_valid & ~lsq_full & ~branch;

   always_comb begin
      w_new           = '0;
      w_new.valid     = 1'b1;
      w_new.operation = disp_operation;
      w_new.funct3    = disp_funct3;
      w_new.offset    = disp_offset;
      w_new.ps1       = disp_ps1;
      w_new.ps1_ready = operand_ready(disp_ps1_ready, disp_ps1, cdb_valid, cdb_phys_reg);
      w_new.ps2       = disp_ps2;
      w_new.ps2_ready = disp_operation ?
                        operand_ready(disp_ps2_ready, disp_ps2, cdb_valid, cdb_phys_reg) : 1'b1;
      w_new.wrob      = disp_wrob;
      w_new.arch_dest = disp_arch_dest;
      w_new.pdest     = disp_pdest;
   end

   always_ff @(posedge clk) begin
      if (rst | branch) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_ls_pkg    <= '0;
         r_issue_ps1 <= '0;
         r_issue_ps2 <= '0;
         for (int i = 0; i < LSQ_DEPTH; i++) begin
            r_entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LSQ_DEPTH; i++) begin
            if (w_wake1[i]) r_entries[i].ps1_ready <= 1'b1;
            if (w_wake2[i]) r_entries[i].ps2_ready <= 1'b1;
         end

         r_ls_pkg.ls_valid <= w_issue;
         if (w_issue) begin
            r_entries[r_head].valid <= 1'b0;
            r_ls_pkg.operation      <= w_head.operation;
            r_ls_pkg.funct3         <= w_head.funct3;
            r_ls_pkg.offset         <= w_head.offset;
            r_ls_pkg.Wrob           <= w_head.wrob;
            r_ls_pkg.archDest       <= w_head.arch_dest;
            r_ls_pkg.pDest          <= w_head.pdest;
            r_issue_ps1             <= w_head.ps1;
            r_issue_ps2             <= w_head.ps2;
            r_head                  <= r_head + C_PTR_ONE;
         end

         // Tail never aliases an issuing head: that needs count 0 or full.
         if (w_disp) begin
            r_entries[r_tail] <= w_new;
            r_tail            <= r_tail + C_PTR_ONE;
         end

         case ({w_disp, w_issue})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign ls_pkg    = r_ls_pkg;
   assign issue_ps1 = r_issue_ps1;
   assign issue_ps2 = r_issue_ps2;

endmodule
`default_nettype wire

// File: tb/tb_load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_queue
// Description : Directed table + sequence bench for load_store_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_queue;
   import load_store_queue_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst, branch, disp_valid, disp_operation;
   logic [2:0]                 disp_funct3;
   logic [31:0]                disp_offset;
   logic [PR_WIDTH-1:0]        disp_ps1, disp_ps2, disp_pdest, cdb_phys_reg;
   logic                       disp_ps1_ready, disp_ps2_ready, cdb_valid, mem_fu_ready;
   logic [ROB_WIDTH-1:0]       disp_wrob, rob_head;
   logic [4:0]                 disp_arch_dest;
   logic                       lsq_full, lsq_empty;
   loadStoreReservationEntry_t ls_pkg;
   logic [PR_WIDTH-1:0]        issue_ps1, issue_ps2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   load_store_queue #(.LSQ_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .branch(branch),
      .disp_valid(disp_valid), .disp_operation(disp_operation), .disp_funct3(disp_funct3),
      .disp_offset(disp_offset), .disp_ps1(disp_ps1), .disp_ps1_ready(disp_ps1_ready),
      .disp_ps2(disp_ps2), .disp_ps2_ready(disp_ps2_ready), .disp_wrob(disp_wrob),
      .disp_arch_dest(disp_arch_dest), .disp_pdest(disp_pdest), .rob_head(rob_head),
      .cdb_valid(cdb_valid), .cdb_phys_reg(cdb_phys_reg), .mem_fu_ready(mem_fu_ready),
      .lsq_full(lsq_full), .lsq_empty(lsq_empty), .ls_pkg(ls_pkg),
      .issue_ps1(issue_ps1), .issue_ps2(issue_ps2)
   );

   typedef struct {
      logic                rst;
      logic                dv;
      logic [31:0]         off;
      logic [PR_WIDTH-1:0] ps1;
      logic                r1;
      logic [PR_WIDTH-1:0] pd;
      logic                cv;
      logic [PR_WIDTH-1:0] cr;
      logic                e_valid;
      logic                e_empty;
      logic [PR_WIDTH-1:0] e_pd;
      logic [PR_WIDTH-1:0] e_ps1;
      logic [31:0]         e_off;
   } vec_t;

   localparam int NVEC = 20;
   vec_t tbl [NVEC];

   function automatic vec_t mk(input logic r, input logic dv, input logic [31:0] off,
                               input logic [PR_WIDTH-1:0] ps1, input logic r1,
                               input logic [PR_WIDTH-1:0] pd, input logic cv,
                               input logic [PR_WIDTH-1:0] cr, input logic ev, input logic ee,
                               input logic [PR_WIDTH-1:0] epd, input logic [PR_WIDTH-1:0] eps1,
                               input logic [31:0] eoff);
      vec_t v;
      v.rst = r; v.dv = dv; v.off = off; v.ps1 = ps1; v.r1 = r1; v.pd = pd;
      v.cv = cv; v.cr = cr; v.e_valid = ev; v.e_empty = ee;
      v.e_pd = epd; v.e_ps1 = eps1; v.e_off = eoff;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      rst = 1'b0; branch = 1'b0; disp_valid = 1'b0; disp_operation = 1'b0;
      disp_funct3 = 3'd2; disp_offset = '0; disp_ps1 = '0; disp_ps1_ready = 1'b0;
      disp_ps2 = '0; disp_ps2_ready = 1'b0; disp_wrob = '0; disp_arch_dest = 5'd1;
      disp_pdest = '0; cdb_valid = 1'b0; cdb_phys_reg = '0;
   endtask

   task automatic load(input logic [31:0] off, input logic [PR_WIDTH-1:0] ps1,
                       input logic r1, input logic [PR_WIDTH-1:0] pd);
      disp_valid = 1'b1; disp_operation = 1'b0; disp_offset = off;
      disp_ps1 = ps1; disp_ps1_ready = r1; disp_pdest = pd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic ev, input logic ee, input logic ef);
      tick();
      chk({tag, ".ls_valid"}, 32'(ls_pkg.ls_valid), 32'(ev));
      chk({tag, ".empty"}, 32'(lsq_empty), 32'(ee));
      chk({tag, ".full"}, 32'(lsq_full), 32'(ef));
   endtask

   initial begin
      idle();
      rst = 1'b1; mem_fu_ready = 1'b1; rob_head = '0;

      //              rst dv off    ps1 r1 pd  cv cr ev ee epd eps1 eoff
      tbl[0]  = mk(1, 0, 32'h00,  0, 0,  0, 0, 0, 0, 1,  0, 0, 32'h00);
      tbl[1]  = mk(0, 1, 32'h10,  3, 1,  9, 0, 0, 0, 0,  0, 0, 32'h00);
      tbl[2]  = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 1, 1,  9, 3, 32'h10);
      tbl[3]  = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 0, 1,  0, 0, 32'h00);
      tbl[4]  = mk(0, 1, 32'h20,  7, 0, 12, 0, 0, 0, 0,  0, 0, 32'h00);
      tbl[5]  = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h00);
      tbl[6]  = mk(0, 0, 32'h00,  0, 0,  0, 1, 7, 0, 0,  0, 0, 32'h00);
      tbl[7]  = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 1, 1, 12, 7, 32'h20);
      tbl[8]  = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 0, 1,  0, 0, 32'h00);
      tbl[9]  = mk(0, 1, 32'h30,  5, 0, 14, 1, 5, 0, 0,  0, 0, 32'h00);
      tbl[10] = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 1, 1, 14, 5, 32'h30);
      tbl[11] = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 0, 1,  0, 0, 32'h00);
      tbl[12] = mk(0, 1, 32'h40,  0, 0, 15, 0, 0, 0, 0,  0, 0, 32'h00);
      tbl[13] = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 1, 1, 15, 0, 32'h40);
      tbl[14] = mk(0, 1, 32'h50,  8, 0, 16, 0, 0, 0, 0,  0, 0, 32'h00);
      tbl[15] = mk(0, 0, 32'h00,  0, 0,  0, 1, 9, 0, 0,  0, 0, 32'h00);
      tbl[16] = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h00);
      tbl[17] = mk(0, 0, 32'h00,  0, 0,  0, 1, 8, 0, 0,  0, 0, 32'h00);
      tbl[18] = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 1, 1, 16, 8, 32'h50);
      tbl[19] = mk(0, 0, 32'h00,  0, 0,  0, 0, 0, 0, 1,  0, 0, 32'h00);

      for (int i = 0; i < NVEC; i++) begin
         idle();
         rst = tbl[i].rst;
         if (tbl[i].dv) load(tbl[i].off, tbl[i].ps1, tbl[i].r1, tbl[i].pd);
         cdb_valid = tbl[i].cv; cdb_phys_reg = tbl[i].cr;
         step($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_empty, 1'b0);
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d.pdest", i), 32'(ls_pkg.pDest), 32'(tbl[i].e_pd));
            chk($sformatf("vec%0d.issue_ps1", i), 32'(issue_ps1), 32'(tbl[i].e_ps1));
            chk($sformatf("vec%0d.offset", i), ls_pkg.offset, tbl[i].e_off);
         end
      end

      // Store waits for ROB head; the younger load behind it waits too.
      idle(); rob_head = 4'd2;
      disp_valid = 1'b1; disp_operation = 1'b1; disp_funct3 = 3'd1; disp_offset = 32'h60;
      disp_ps1 = 6'd4; disp_ps1_ready = 1'b1; disp_ps2 = 6'd6; disp_ps2_ready = 1'b1;
      disp_wrob = 4'd3;
      step("st.disp", 1'b0, 1'b0, 1'b0);
      idle(); load(32'h70, 6'd4, 1'b1, 6'd20); disp_wrob = 4'd4;
      step("st.disp_ld", 1'b0, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) step("st.wait", 1'b0, 1'b0, 1'b0);
      rob_head = 4'd3;
      step("st.issue", 1'b1, 1'b0, 1'b0);
      chk("st.op", 32'(ls_pkg.operation), 32'd1);
      chk("st.funct3", 32'(ls_pkg.funct3), 32'd1);
      chk("st.wrob", 32'(ls_pkg.Wrob), 32'd3);
      chk("st.ps2", 32'(issue_ps2), 32'd6);
      step("st.pulse", 1'b0, 1'b0, 1'b0);
      step("ld.issue", 1'b1, 1'b1, 1'b0);
      chk("ld.op", 32'(ls_pkg.operation), 32'd0);
      chk("ld.pdest", 32'(ls_pkg.pDest), 32'd20);
      step("ld.pulse", 1'b0, 1'b1, 1'b0);

      // Fill to full, ninth dispatch dropped, drain in order, tail wraps.
      idle(); rst = 1'b1;
      step("fill.rst", 1'b0, 1'b1, 1'b0);
      idle(); mem_fu_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         load(32'(4 * i), 6'd1, 1'b1, 6'(30 + i));
         step($sformatf("fill%0d", i), 1'b0, 1'b0, (i == 7));
      end
      load(32'hff, 6'd1, 1'b1, 6'd63);
      step("fill.ninth", 1'b0, 1'b0, 1'b1);
      idle(); mem_fu_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step($sformatf("drain%0d", i), 1'b1, (i == 7), 1'b0);
         chk($sformatf("drain%0d.pdest", i), 32'(ls_pkg.pDest), 32'(30 + i));
         chk($sformatf("drain%0d.offset", i), ls_pkg.offset, 32'(4 * i));
         step($sformatf("drain%0d.gap", i), 1'b0, (i == 7), 1'b0);
      end
      load(32'h80, 6'd2, 1'b1, 6'd40);
      step("wrap.disp", 1'b0, 1'b0, 1'b0);
      load(32'h84, 6'd2, 1'b1, 6'd41);
      step("wrap.both", 1'b1, 1'b0, 1'b0);
      chk("wrap.pdest0", 32'(ls_pkg.pDest), 32'd40);
      idle();
      step("wrap.gap", 1'b0, 1'b0, 1'b0);
      step("wrap.issue1", 1'b1, 1'b1, 1'b0);
      chk("wrap.pdest1", 32'(ls_pkg.pDest), 32'd41);
      step("wrap.end", 1'b0, 1'b1, 1'b0);

      // Branch flush with 5 entries queued and ls_valid high.
      idle(); mem_fu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load(32'h90, 6'd3, 1'b1, 6'(50 + i));
         step($sformatf("br.fill%0d", i), 1'b0, 1'b0, 1'b0);
      end
      idle(); mem_fu_ready = 1'b1;
      step("br.issue", 1'b1, 1'b0, 1'b0);
      chk("br.pdest", 32'(ls_pkg.pDest), 32'd50);
      load(32'ha0, 6'd3, 1'b1, 6'd60); branch = 1'b1;
      step("br.flush", 1'b0, 1'b1, 1'b0);
      chk("br.ps1", 32'(issue_ps1), 32'd0);
      chk("br.pkg", 32'(ls_pkg.pDest), 32'd0);
      idle();
      step("br.after", 1'b0, 1'b1, 1'b0);
      step("br.after2", 1'b0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
